// File: rtl/fetch_unit_if.sv
// Handshake bundle between fetch_unit, instruction memory, execute (redirect) and the decoder.
// The master modport is the fetch unit's view; slave is the surrounding environment.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, Instr, PC, PCPlus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, Instr, PC, PCPlus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests, buffers responses
// in an in-order prefetch FIFO and handles execute redirects by flushing and discarding.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  fu_io
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q [FIFO_DEPTH];
    logic [31:0] ipc_q   [FIFO_DEPTH];
    logic [31:0] tag_q   [FIFO_DEPTH];
    ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    cnt_t        count_q, count_d, outst_q, outst_d, discard_q, discard_d;

    logic        redirect;
    logic        rsp_eff;
    logic        accept;
    logic        push;
    logic        pop;
    logic [CW:0] inflight;

    assign redirect = fu_io.redirect_valid;
    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_eff  = fu_io.imem_rsp_valid && (outst_q != '0);
    assign inflight = {1'b0, outst_q} + {1'b0, count_q};

    assign fu_io.imem_req_valid = !reset && !redirect && (inflight < (CW + 1)'(FIFO_DEPTH));
    assign fu_io.imem_req_addr  = fetch_pc_q;
    assign fu_io.instr_valid    = (count_q != '0) && !redirect;
    assign fu_io.Instr          = instr_q[rd_ptr_q];
    assign fu_io.PC             = ipc_q[rd_ptr_q];
    assign fu_io.PCPlus4        = ipc_q[rd_ptr_q] + 32'd4;

    assign accept = fu_io.imem_req_valid && fu_io.imem_req_ready;
    assign push   = rsp_eff && !redirect && (discard_q == '0);
    assign pop    = fu_io.instr_valid && fu_io.instr_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + cnt_t'(accept) - cnt_t'(rsp_eff);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = ptr_inc(tag_wr_q);
        end
        if (rsp_eff) begin
            tag_rd_d = ptr_inc(tag_rd_q);
        end

        if (redirect) begin
            fetch_pc_d = {fu_io.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight, minus a response landing right now, is stale.
            discard_d  = outst_q - cnt_t'(rsp_eff);
        end else begin
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (rsp_eff && (discard_q != '0)) begin
                discard_d = discard_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (accept) begin
                tag_q[tag_wr_q] <= fetch_pc_q;
            end
            if (push) begin
                instr_q[wr_ptr_q] <= fu_io.imem_rsp_data;
                ipc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a variable-latency memory model plus an epoch-based
// transaction model of which words must reach the consumer, in what order, and when.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH    = 3;

    logic clk = 1'b0;
    logic reset;
    fetch_unit_if fu_if ();

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fu_io (fu_if)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        longint      due;
    } req_t;

    req_t        mem_q[$];
    req_t        rsp_ent;
    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;
    longint      last_due = 0;
    int unsigned epoch       = 1;
    int unsigned reset_floor = 1;
    int unsigned rsp_epoch   = 0;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    int          buffered = 0;
    int          delivered = 0;
    logic [31:0] exp_pc  = RESET_PC;
    logic [31:0] req_exp = RESET_PC;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory: in-order, one response per accepted request, unstallable.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            rsp_ent = mem_q.pop_front();
            fu_if.imem_rsp_valid = 1'b1;
            fu_if.imem_rsp_data  = mem_word(rsp_ent.addr);
            rsp_epoch            = rsp_ent.epoch;
        end else begin
            fu_if.imem_rsp_valid = 1'b0;
            fu_if.imem_rsp_data  = $urandom;
        end
    end

    // Transaction model: after reset/redirect to T, the consumer sees T, T+4, ... exactly once.
    always @(negedge clk) begin
        if (!reset) begin
            int  outst;
            int  lat;
            bit  redir;
            outst = 0;
            foreach (mem_q[i]) if (mem_q[i].epoch >= reset_floor) outst++;
            if (fu_if.imem_rsp_valid && rsp_epoch >= reset_floor) outst++;
            redir = fu_if.redirect_valid;

            check_eq("instr_valid", 32'(fu_if.instr_valid), 32'(buffered != 0 && !redir));
            check_eq("req_valid", 32'(fu_if.imem_req_valid),
                     32'(!redir && (outst + buffered < DEPTH)));
            if (fu_if.imem_req_valid) check_eq("req_addr", fu_if.imem_req_addr, req_exp);

            if (redir) begin
                epoch++;
                buffered = 0;
                exp_pc   = {fu_if.redirect_pc[31:2], 2'b00};
                req_exp  = {fu_if.redirect_pc[31:2], 2'b00};
            end else begin
                if (fu_if.imem_rsp_valid && rsp_epoch == epoch) buffered++;
                if (fu_if.instr_valid && fu_if.instr_ready) begin
                    check_eq("pc", fu_if.PC, exp_pc);
                    check_eq("instr", fu_if.Instr, mem_word(exp_pc));
                    check_eq("pcplus4", fu_if.PCPlus4, exp_pc + 32'd4);
                    buffered--;
                    delivered++;
                    exp_pc = exp_pc + 32'd4;
                end
                if (fu_if.imem_req_valid && fu_if.imem_req_ready) begin
                    lat = int'($urandom_range(lat_max, lat_min));
                    last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                    mem_q.push_back('{addr: fu_if.imem_req_addr, epoch: epoch, due: last_due});
                    req_exp = req_exp + 32'd4;
                end
            end
        end
    end

    task automatic drive_cycle(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        fu_if.imem_req_ready = rr;
        fu_if.instr_ready    = ir;
        fu_if.redirect_valid = rv;
        fu_if.redirect_pc    = rpc;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_valid", 32'(fu_if.imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(fu_if.instr_valid), 32'd0);
        check_eq("rst_req_addr", fu_if.imem_req_addr, RESET_PC);
        check_eq("rst_instr", fu_if.Instr, 32'd0);
        check_eq("rst_pc", fu_if.PC, 32'd0);
        check_eq("rst_pcplus4", fu_if.PCPlus4, 32'd4);
    endtask

    // Holds reset until pre-reset responses have drained, so strays land at or before release.
    task automatic release_reset();
        int n;
        n = 0;
        while (mem_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("reset_drain_timeout", 32'(mem_q.size()), 32'd0);
        reset = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        fu_if.redirect_valid = 1'b0;
        epoch++;
        reset_floor = epoch;
        buffered    = 0;
        exp_pc      = RESET_PC;
        req_exp     = RESET_PC;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #2;
        release_reset();
    endtask

    initial begin
        int n;
        int d0;
        bit rv;
        reset                = 1'b0;
        fu_if.imem_req_ready = 1'b1;
        fu_if.imem_rsp_valid = 1'b0;
        fu_if.imem_rsp_data  = '0;
        fu_if.redirect_valid = 1'b0;
        fu_if.redirect_pc    = '0;
        fu_if.instr_ready    = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #2;
        release_reset();

        // Latency from reset release to first valid instruction, then full throughput.
        n = 0;
        @(negedge clk);
        while (!fu_if.instr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_valid_cycle", 32'(n), 32'd2);
        @(posedge clk);
        #2;
        d0 = delivered;
        repeat (10) @(posedge clk);
        #2;
        check_eq("throughput_10", 32'(delivered - d0), 32'd10);

        // Consumer stall: credits fill up and requests stop.
        fu_if.instr_ready = 1'b0;
        repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        #1;
        check_eq("stall_req_valid", 32'(fu_if.imem_req_valid), 32'd0);
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect with 3-cycle memory and requests in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect coinciding with a response; low address bits are ignored.
        lat_min = 1;
        lat_max = 1;
        repeat (6) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0303);
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Reset while stalled with words buffered and requests outstanding.
        lat_min = 3;
        lat_max = 3;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        do_reset();
        repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                lat_min = $urandom_range(3, 1);
                lat_max = lat_min + $urandom_range(2, 0);
            end
            if ($urandom_range(399, 0) == 0) do_reset();
            rv = ($urandom_range(24, 0) == 0);
            drive_cycle($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, rv, $urandom);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
